// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for the 5-stage RV64 pipeline: stalls, flushes, forwarding selects and a cache-miss freeze FSM.
// Optional saturating performance counters are compiled in with `define PIPELINE_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_d,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_d,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_e,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_e,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_e,
  input  logic                  i_load_instr_e,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_m,
  input  logic                  i_reg_we_m,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_w,
  input  logic                  i_reg_we_w,
  input  logic                  i_pc_src_e,
  input  logic                  i_mem_stall_req,
  input  logic                  i_mem_ready,
  output logic                  o_stall_fetch,
  output logic                  o_stall_decode,
  output logic                  o_stall_exec,
  output logic                  o_stall_mem,
  output logic                  o_stall_wb,
  output logic                  o_flush_decode,
  output logic                  o_flush_exec,
  output logic [1:0]            o_forward_a_e,
  output logic [1:0]            o_forward_b_e,
  output logic [1:0]            o_state
`ifdef PIPELINE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  o_cnt_freeze,
  output logic [CNT_WIDTH-1:0]  o_cnt_lu,
  output logic [CNT_WIDTH-1:0]  o_cnt_flush
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    MISS   = 2'b01,
    RESUME = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   freeze;
  logic   lu;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  we_w
  );
    if (we_m && (rd_m != '0) && (rd_m == rs))      fwd_sel = 2'b10;
    else if (we_w && (rd_w != '0) && (rd_w == rs)) fwd_sel = 2'b01;
    else                                           fwd_sel = 2'b00;
  endfunction

  assign o_forward_a_e = fwd_sel(i_rs1_addr_e, i_rd_addr_m, i_reg_we_m, i_rd_addr_w, i_reg_we_w);
  assign o_forward_b_e = fwd_sel(i_rs2_addr_e, i_rd_addr_m, i_reg_we_m, i_rd_addr_w, i_reg_we_w);

  assign freeze = (state_q != RUN) || i_mem_stall_req;
  assign lu     = i_load_instr_e && (i_rd_addr_e != '0) &&
                  ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= RUN;
    else        state_q <= state_d;
  end

  // RESUME is a fixed single cycle so registered refill data can settle
  always_comb begin
    state_d        = state_q;
    o_stall_fetch  = 1'b0;
    o_stall_decode = 1'b0;
    o_stall_exec   = 1'b0;
    o_stall_mem    = 1'b0;
    o_stall_wb     = 1'b0;
    o_flush_decode = 1'b0;
    o_flush_exec   = 1'b0;
    case (state_q)
      RUN: begin
        if (i_mem_stall_req && i_mem_ready) state_d = RESUME;
        else if (i_mem_stall_req)           state_d = MISS;
      end
      MISS:    if (i_mem_ready) state_d = RESUME;
      RESUME:  state_d = RUN;
      default: state_d = RUN;
    endcase
    if (freeze) begin
      o_stall_fetch  = 1'b1;
      o_stall_decode = 1'b1;
      o_stall_exec   = 1'b1;
      o_stall_mem    = 1'b1;
      o_stall_wb     = 1'b1;
    end else begin
      // Decode sees both stall and flush on lu+branch; its register lets flush win
      o_stall_fetch  = lu;
      o_stall_decode = lu;
      o_flush_decode = i_pc_src_e;
      o_flush_exec   = lu || i_pc_src_e;
    end
  end

  assign o_state = state_q;

`ifdef PIPELINE_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_freeze_q, cnt_freeze_d;
  logic [CNT_WIDTH-1:0] cnt_lu_q,     cnt_lu_d;
  logic [CNT_WIDTH-1:0] cnt_flush_q,  cnt_flush_d;

  always_comb begin
    cnt_freeze_d = cnt_freeze_q;
    cnt_lu_d     = cnt_lu_q;
    cnt_flush_d  = cnt_flush_q;
    if (freeze && (cnt_freeze_q != '1))              cnt_freeze_d = cnt_freeze_q + CNT_ONE;
    if (!freeze && lu && (cnt_lu_q != '1))           cnt_lu_d     = cnt_lu_q + CNT_ONE;
    if (!freeze && i_pc_src_e && (cnt_flush_q != '1)) cnt_flush_d = cnt_flush_q + CNT_ONE;
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cnt_freeze_q <= '0;
      cnt_lu_q     <= '0;
      cnt_flush_q  <= '0;
    end else begin
      cnt_freeze_q <= cnt_freeze_d;
      cnt_lu_q     <= cnt_lu_d;
      cnt_flush_q  <= cnt_flush_d;
    end
  end

  assign o_cnt_freeze = cnt_freeze_q;
  assign o_cnt_lu     = cnt_lu_q;
  assign o_cnt_flush  = cnt_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: combinational vector table in RUN plus multi-cycle freeze sequences.
module tb_pipeline_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;

  logic          i_clk = 1'b0;
  logic          i_arst;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          load_e, we_m, we_w, pc_src, req, ready;
  logic          sf, sd, se, sm, sw, fd, fe;
  logic [1:0]    fa, fb, st;
`ifdef PIPELINE_PERF_CNT_EN
  logic [CW-1:0] cnt_freeze, cnt_lu, cnt_flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  pipeline_ctrl #(.REG_ADDR_W(AW), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_arst(i_arst),
    .i_rs1_addr_d(rs1_d), .i_rs2_addr_d(rs2_d),
    .i_rs1_addr_e(rs1_e), .i_rs2_addr_e(rs2_e),
    .i_rd_addr_e(rd_e), .i_load_instr_e(load_e),
    .i_rd_addr_m(rd_m), .i_reg_we_m(we_m),
    .i_rd_addr_w(rd_w), .i_reg_we_w(we_w),
    .i_pc_src_e(pc_src), .i_mem_stall_req(req), .i_mem_ready(ready),
    .o_stall_fetch(sf), .o_stall_decode(sd), .o_stall_exec(se),
    .o_stall_mem(sm), .o_stall_wb(sw),
    .o_flush_decode(fd), .o_flush_exec(fe),
    .o_forward_a_e(fa), .o_forward_b_e(fb), .o_state(st)
`ifdef PIPELINE_PERF_CNT_EN
    , .o_cnt_freeze(cnt_freeze), .o_cnt_lu(cnt_lu), .o_cnt_flush(cnt_flush)
`endif
  );

  // {stall f,d,e,m,w, flush d, flush e, fwd a, fwd b, state}
  logic [12:0] got;
  assign got = {sf, sd, se, sm, sw, fd, fe, fa, fb, st};

  typedef struct {
    string         name;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          load_e, we_m, we_w, pc_src;
    logic [12:0]   exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    load_e = 0; we_m = 0; we_w = 0; pc_src = 0; req = 0; ready = 0;
  endtask

  // Drive on the falling edge, sample 1 ns later, before the next rising edge.
  task automatic drive_edge();
    @(negedge i_clk);
  endtask

  initial begin
    vecs[0]  = '{"idle",       0,0,0,0,0, 0,0, 0,0,0,0, {5'b00000,2'b00,2'b00,2'b00,2'b00}};
    vecs[1]  = '{"fwd_b_mem",  0,0,0,7,0, 7,7, 0,1,1,0, {5'b00000,2'b00,2'b00,2'b10,2'b00}};
    vecs[2]  = '{"fwd_b_wb",   0,0,0,7,0, 0,7, 0,1,1,0, {5'b00000,2'b00,2'b00,2'b01,2'b00}};
    vecs[3]  = '{"fwd_b_x0",   0,0,0,0,0, 7,7, 0,1,1,0, {5'b00000,2'b00,2'b00,2'b00,2'b00}};
    vecs[4]  = '{"fwd_a_mem",  0,0,3,0,0, 3,0, 0,1,0,0, {5'b00000,2'b00,2'b10,2'b00,2'b00}};
    vecs[5]  = '{"fwd_a_wb",   0,0,3,0,0, 3,3, 0,0,1,0, {5'b00000,2'b00,2'b01,2'b00,2'b00}};
    vecs[6]  = '{"lu_x0",      0,0,0,0,0, 0,0, 1,0,0,0, {5'b00000,2'b00,2'b00,2'b00,2'b00}};
    vecs[7]  = '{"lu_rs2",     0,9,0,0,9, 0,0, 1,0,0,0, {5'b11000,2'b01,2'b00,2'b00,2'b00}};
    vecs[8]  = '{"no_load",    0,9,0,0,9, 0,0, 0,0,0,0, {5'b00000,2'b00,2'b00,2'b00,2'b00}};
    vecs[9]  = '{"branch",     0,0,0,0,0, 0,0, 0,0,0,1, {5'b00000,2'b11,2'b00,2'b00,2'b00}};
    vecs[10] = '{"lu_branch",  4,0,0,0,4, 0,0, 1,0,0,1, {5'b11000,2'b11,2'b00,2'b00,2'b00}};
    vecs[11] = '{"wb_rd_x0",   0,0,0,0,0, 0,0, 0,0,1,0, {5'b00000,2'b00,2'b00,2'b00,2'b00}};

    clear_inputs();
    i_arst = 1'b1;
    #1;
    check("reset_state", 13'b0);
`ifdef PIPELINE_PERF_CNT_EN
    checks++;
    if ({cnt_freeze, cnt_lu, cnt_flush} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", cnt_freeze, cnt_lu, cnt_flush);
    end
`endif
    drive_edge();
    drive_edge();
    i_arst = 1'b0;

    foreach (vecs[i]) begin
      drive_edge();
      clear_inputs();
      rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d;
      rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e;
      rd_e  = vecs[i].rd_e;  rd_m  = vecs[i].rd_m;  rd_w = vecs[i].rd_w;
      load_e = vecs[i].load_e; we_m = vecs[i].we_m; we_w = vecs[i].we_w;
      pc_src = vecs[i].pc_src;
      #1 check(vecs[i].name, vecs[i].exp);
    end

    // Load-use lasts one cycle: bubble in execute clears it
    drive_edge(); clear_inputs();
    load_e = 1; rd_e = 5; rs1_d = 5;
    #1 check("lu_cycle0", {5'b11000, 2'b01, 6'b0});
    drive_edge();
    load_e = 0; rd_e = 0;
    #1 check("lu_cycle1", 13'b0);

    // Miss: request 4 cycles, ready on the 4th
    drive_edge(); clear_inputs(); req = 1;
    #1 check("miss_c0", {5'b11111, 8'b0});
    for (int c = 1; c <= 3; c++) begin
      drive_edge();
      if (c == 3) ready = 1;
      #1 check($sformatf("miss_c%0d", c), {5'b11111, 6'b0, 2'b01});
    end
    drive_edge(); req = 0; ready = 0;
    #1 check("miss_resume", {5'b11111, 6'b0, 2'b10});
    drive_edge();
    #1 check("miss_run", 13'b0);

    // Branch held during a miss is acted on in the first unfrozen cycle
    drive_edge(); clear_inputs(); req = 1; pc_src = 1;
    #1 check("br_req", {5'b11111, 8'b0});
    drive_edge();
    #1 check("br_miss", {5'b11111, 6'b0, 2'b01});
    drive_edge(); ready = 1;
    #1 check("br_miss_rdy", {5'b11111, 6'b0, 2'b01});
    drive_edge(); req = 0; ready = 0;
    #1 check("br_resume", {5'b11111, 6'b0, 2'b10});
    drive_edge();
    #1 check("br_run", {5'b00000, 2'b11, 6'b0});

    // Same-cycle ready goes straight to RESUME
    drive_edge(); clear_inputs(); req = 1; ready = 1;
    #1 check("same_run", {5'b11111, 8'b0});
    drive_edge(); req = 0; ready = 0;
    #1 check("same_resume", {5'b11111, 6'b0, 2'b10});
    drive_edge();
    #1 check("same_back", 13'b0);

    // Reset in MISS aborts the freeze at once
    drive_edge(); clear_inputs(); req = 1;
    drive_edge();
    #1 check("rst_in_miss", {5'b11111, 6'b0, 2'b01});
    drive_edge(); req = 0; i_arst = 1'b1;
    #1 check("rst_abort", 13'b0);
`ifdef PIPELINE_PERF_CNT_EN
    checks++;
    if ({cnt_freeze, cnt_lu, cnt_flush} !== '0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d/%0d/%0d expected 0/0/0", cnt_freeze, cnt_lu, cnt_flush);
    end
`endif
    drive_edge(); i_arst = 1'b0;
    drive_edge();
    #1 check("post_rst", 13'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard and stall sequencer for the 5-stage RV64 pipeline.
- Generates stall/flush strobes for the fetch, decode, execute, memory and writeback pipeline registers, including the decode→execute flush input.
- Produces the execute-stage forwarding selects.
- A small FSM freezes the whole pipeline across multi-cycle cache misses and releases it cleanly.

Parameters:
REG_ADDR_W, 5, register address width
CNT_WIDTH, 32, width of optional performance counters

Ports:
i_clk  in  1  clock
i_arst  in  1  reset, asynchronous, active-high
i_rs1_addr_d  in  REG_ADDR_W  rs1 of instruction in decode
i_rs2_addr_d  in  REG_ADDR_W  rs2 of instruction in decode
i_rs1_addr_e  in  REG_ADDR_W  rs1 of instruction in execute
i_rs2_addr_e  in  REG_ADDR_W  rs2 of instruction in execute
i_rd_addr_e  in  REG_ADDR_W  rd in execute
i_load_instr_e  in  1  execute holds a load
i_rd_addr_m  in  REG_ADDR_W  rd in memory stage
i_reg_we_m  in  1  memory-stage register write enable
i_rd_addr_w  in  REG_ADDR_W  rd in writeback
i_reg_we_w  in  1  writeback register write enable
i_pc_src_e  in  1  branch taken / jump resolved in execute
i_mem_stall_req  in  1  I- or D-cache miss pending
i_mem_ready  in  1  miss serviced, data valid this cycle
o_stall_fetch  out  1  hold PC
o_stall_decode  out  1  hold fetch→decode register
o_stall_exec  out  1  hold decode→execute register
o_stall_mem  out  1  hold execute→memory register
o_stall_wb  out  1  hold memory→writeback register
o_flush_decode  out  1  clear fetch→decode register
o_flush_exec  out  1  clear decode→execute register
o_forward_a_e  out  2  rs1 operand select: 00 regfile, 01 writeback, 10 memory
o_forward_b_e  out  2  rs2 operand select, same encoding
o_state  out  2  FSM state: 00 RUN, 01 MISS, 10 RESUME

Behaviour:
Reset:
- i_arst drives the FSM to RUN.
- All registered outputs are 0.
- Combinational outputs follow the RUN equations.
- Reset during MISS or RESUME aborts the freeze immediately; stalls deassert in the same cycle.

Definitions:
- freeze = (state != RUN) | (state == RUN & i_mem_stall_req).
- lu = i_load_instr_e & (i_rd_addr_e != 0) & (i_rd_addr_e == i_rs1_addr_d | i_rd_addr_e == i_rs2_addr_d).

Forwarding (combinational, valid in every state, identical for a and b):
- Select 10 if i_reg_we_m & rd_m != 0 & rd_m == rs_e.
- Else select 01 if i_reg_we_w & rd_w != 0 & rd_w == rs_e.
- Else select 00.
- Memory stage wins when both match.

FSM:
- RUN: if i_mem_stall_req and i_mem_ready → RESUME; if i_mem_stall_req alone → MISS; else stay in RUN.
- MISS: stay until i_mem_ready = 1, then → RESUME.
- RESUME: exactly one cycle, then → RUN. This cycle lets the cache's registered refill data settle.

Outputs when freeze = 1:
- All five o_stall_* = 1.
- o_flush_decode = 0 and o_flush_exec = 0; flushes are suppressed.
- Load-use detection is ignored.
- A pending i_pc_src_e stays asserted (execute is frozen) and is acted on in the first unfrozen RUN cycle.

Outputs in RUN with freeze = 0:
- o_stall_fetch = o_stall_decode = lu.
- o_stall_exec = o_stall_mem = o_stall_wb = 0.
- o_flush_exec = lu | i_pc_src_e.
- o_flush_decode = i_pc_src_e.

Simultaneous events:
- lu and i_pc_src_e together: flush wins for decode (o_flush_decode = 1, o_stall_decode = 1 both asserted; the decode register gives flush priority).
- A load-use stall lasts exactly one cycle, because the execute bubble clears the condition.
- Register x0 never forwards and never causes a stall.

Optional Feature:
PIPELINE_PERF_CNT_EN
- Defined: adds outputs o_cnt_freeze, o_cnt_lu, o_cnt_flush, each CNT_WIDTH bits, reset to 0.
  - o_cnt_freeze increments each cycle freeze = 1.
  - o_cnt_lu increments each unfrozen cycle lu = 1.
  - o_cnt_flush increments each unfrozen cycle i_pc_src_e = 1.
  - All counters saturate at all-ones.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: i_load_instr_e = 1, rd_e = 5, rs1_d = 5 in RUN → for one cycle o_stall_fetch = o_stall_decode = 1, o_flush_exec = 1; next cycle (bubble in execute) all 0.
- Forwarding priority: rd_m = rd_w = 7, both write enables high, rs2_e = 7 → o_forward_b_e = 10. Repeat with rd_m = 0 → 01. Repeat with rs2_e = 0 → 00.
- Miss: i_mem_stall_req high 4 cycles, i_mem_ready on the 4th → o_state goes 00, 01, 01, 01, 10, 00. All o_stall_* = 1 from the request cycle through RESUME, 0 afterwards.
- Branch during miss: i_pc_src_e = 1 while in MISS → flushes stay 0 during MISS/RESUME; first RUN cycle gives o_flush_decode = o_flush_exec = 1.
- Same-cycle ready: i_mem_stall_req = i_mem_ready = 1 in RUN → RUN→RESUME→RUN with 2 stall cycles.
- Reset mid-miss: assert i_arst in MISS → o_state = 00 and all stalls 0 immediately. With PIPELINE_PERF_CNT_EN defined, counters read 0.
